// File: rtl/tt_memop_sync_resp_if.sv
// Signal bundle for the vector memop sync responder. The slave side is the
// responder itself and the master side is whoever drives the traffic events.
interface tt_memop_sync_resp_if #(
  parameter int LD_CNT_W = 6,
  parameter int ST_CNT_W = 5
);
  logic                i_memop_sync_start;
  logic                i_ld_issue;
  logic                i_ld_resp;
  logic                i_st_data_valid;
  logic                i_st_drain;
  logic                o_memop_sync_end;
  logic                o_st_credit;
  logic                o_busy;
  logic [LD_CNT_W-1:0] o_ld_outstanding;
  logic [ST_CNT_W-1:0] o_st_occupancy;
  logic                o_err;

  modport slave (
    input  i_memop_sync_start, i_ld_issue, i_ld_resp, i_st_data_valid, i_st_drain,
    output o_memop_sync_end, o_st_credit, o_busy, o_ld_outstanding, o_st_occupancy, o_err
  );

  modport master (
    output i_memop_sync_start, i_ld_issue, i_ld_resp, i_st_data_valid, i_st_drain,
    input  o_memop_sync_end, o_st_credit, o_busy, o_ld_outstanding, o_st_occupancy, o_err
  );
endinterface

// File: rtl/tt_memop_sync_resp.sv
// Core-side memop sync responder: counts outstanding loads and store-buffer
// occupancy, answers each sync-start with a sync-end once traffic has drained.
module tt_memop_sync_resp #(
  parameter int LD_CNT_W   = 6,
  parameter int ST_ENTRIES = 16,
  parameter int ST_CNT_W   = 5
) (
  input  logic i_clk,
  input  logic i_reset_n,
  tt_memop_sync_resp_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_END
  } state_t;

  localparam logic [LD_CNT_W-1:0] LD_MAX  = '1;
  localparam logic [ST_CNT_W-1:0] ST_FULL = ST_CNT_W'(ST_ENTRIES);

  state_t              state_q, state_d;
  logic [LD_CNT_W-1:0] ld_q, ld_d;
  logic [ST_CNT_W-1:0] occ_q, occ_d;
  logic                credit_q, credit_d;
  logic                err_q, err_d;
  logic                ld_err, st_err, start_err;
  logic                drained;

  // Load counter; simultaneous issue and response cancel without error.
  always_comb begin
    ld_d   = ld_q;
    ld_err = 1'b0;
    case ({bus.i_ld_issue, bus.i_ld_resp})
      2'b10: begin
        if (ld_q == LD_MAX) ld_err = 1'b1;
        else                ld_d   = ld_q + LD_CNT_W'(1);
      end
      2'b01: begin
        if (ld_q == '0) ld_err = 1'b1;
        else            ld_d   = ld_q - LD_CNT_W'(1);
      end
      default: ;
    endcase
  end

  // Store occupancy; any drain that is not an underflow earns a credit.
  always_comb begin
    occ_d    = occ_q;
    st_err   = 1'b0;
    credit_d = 1'b0;
    case ({bus.i_st_data_valid, bus.i_st_drain})
      2'b10: begin
        if (occ_q == ST_FULL) st_err = 1'b1;
        else                  occ_d  = occ_q + ST_CNT_W'(1);
      end
      2'b01: begin
        if (occ_q == '0) begin
          st_err = 1'b1;
        end else begin
          occ_d    = occ_q - ST_CNT_W'(1);
          credit_d = 1'b1;
        end
      end
      2'b11:   credit_d = 1'b1;
      default: ;
    endcase
  end

  // Drained is judged on the counts as they will stand after this edge,
  // so the final decrement moves WAIT straight to END.
  assign drained = (ld_d == '0) && (occ_d == '0) &&
                   !bus.i_ld_issue && !bus.i_st_data_valid;

  always_comb begin
    state_d   = state_q;
    start_err = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.i_memop_sync_start) state_d = S_WAIT;
      end
      S_WAIT: begin
        start_err = bus.i_memop_sync_start;
        if (drained) state_d = S_END;
      end
      S_END: begin
        start_err = bus.i_memop_sync_start;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign err_d = err_q | ld_err | st_err | start_err;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= S_IDLE;
      ld_q     <= '0;
      occ_q    <= '0;
      credit_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ld_q     <= ld_d;
      occ_q    <= occ_d;
      credit_q <= credit_d;
      err_q    <= err_d;
    end
  end

  assign bus.o_memop_sync_end = (state_q == S_END);
  assign bus.o_busy           = (state_q != S_IDLE);
  assign bus.o_st_credit      = credit_q;
  assign bus.o_ld_outstanding = ld_q;
  assign bus.o_st_occupancy   = occ_q;
  assign bus.o_err            = err_q;

endmodule
